// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, default datapath width and exec-unit state encoding
package alu_pkg;

   localparam int ALU_XLEN = 32;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_MUL = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

endpackage

// File: rtl/alu_exec_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier keeping the low XLEN product bits; radix-4 when ALU_MUL_RADIX4_EN is defined
module mul_iter import alu_pkg::*; #(
   parameter int XLEN = ALU_XLEN
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [XLEN-1:0] i_mcand,
   input  logic [XLEN-1:0] i_mplier,
   output logic            o_done,
   output logic [XLEN-1:0] o_product
);

`ifdef ALU_MUL_RADIX4_EN
   localparam int ITERS = XLEN / 2;
`else
   localparam int ITERS = XLEN;
`endif
   localparam int CW = $clog2(ITERS);

   logic            r_run;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_acc;
   logic [XLEN-1:0] r_mcand;
   logic [XLEN-1:0] r_mplier;
   logic [XLEN-1:0] w_addend;
   logic [XLEN-1:0] w_mcand_nx;
   logic [XLEN-1:0] w_mplier_nx;

`ifdef ALU_MUL_RADIX4_EN
   assign w_addend    = r_mplier[1] ? (r_mplier[0] ? r_mcand + (r_mcand << 1) : r_mcand << 1)
                                    : (r_mplier[0] ? r_mcand : '0);
   assign w_mcand_nx  = r_mcand << 2;
   assign w_mplier_nx = r_mplier >> 2;
`else
   assign w_addend    = r_mplier[0] ? r_mcand : '0;
   assign w_mcand_nx  = r_mcand << 1;
   assign w_mplier_nx = r_mplier >> 1;
`endif

   // the product of the last iteration is handed out directly so the top can latch it on the done edge
   assign o_done    = r_run && (r_cnt == CW'(ITERS - 1));
   assign o_product = r_acc + w_addend;

   // load operands on start, then retire one multiplier digit per cycle until the last iteration
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_run    <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_run    <= 1'b1;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= i_mcand;
         r_mplier <= i_mplier;
      end else if (r_run) begin
         r_acc    <= o_product;
         r_mcand  <= w_mcand_nx;
         r_mplier <= w_mplier_nx;
         r_cnt    <= o_done ? '0 : r_cnt + 1'b1;
         r_run    <= !o_done;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with single-cycle add/sub/and/or and iterative mul (radix-4 under ALU_MUL_RADIX4_EN)
module alu_exec_unit import alu_pkg::*; #(
   parameter int XLEN = ALU_XLEN
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      ALUCtrl_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] data_o,
   output logic            zero_o,
   output logic            busy_o
);

   state_t          r_state;
   state_t          w_next;
   logic [XLEN-1:0] r_data;
   logic [XLEN-1:0] w_alu;
   logic [XLEN-1:0] w_prod;
   logic            w_accept;
   logic            w_is_mul;
   logic            w_mul_done;

   assign w_accept = req_valid_i && req_ready_o;
   assign w_is_mul = ALUCtrl_i == ALU_MUL;
   assign w_alu    = ALUCtrl_i == ALU_ADD ? data1_i + data2_i
                   : ALUCtrl_i == ALU_SUB ? data1_i - data2_i
                   : ALUCtrl_i == ALU_AND ? data1_i & data2_i
                   : ALUCtrl_i == ALU_OR  ? data1_i | data2_i
                   : '0;

   mul_iter #(.XLEN(XLEN)) u_mul (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_start   (w_accept && w_is_mul),
      .i_mcand   (data1_i),
      .i_mplier  (data2_i),
      .o_done    (w_mul_done),
      .o_product (w_prod)
   );

   // state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // a mul runs to completion; otherwise an accept starts work and DONE drains on resp_ready_i
   always_comb begin
      w_next = r_state == MUL ? (w_mul_done ? DONE : MUL)
             : w_accept ? (w_is_mul ? MUL : DONE)
             : (r_state == DONE && !resp_ready_i) ? DONE : IDLE;
   end

   // handshake outputs; DONE with resp_ready_i high accepts the next request back-to-back
   always_comb begin
      req_ready_o  = r_state == IDLE || (r_state == DONE && resp_ready_i);
      resp_valid_o = r_state == DONE;
      busy_o       = r_state == MUL;
   end

   // result register: single-cycle result on accept, product on the final mul iteration, else hold
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                      r_data <= '0;
      else if (w_accept && !w_is_mul) r_data <= w_alu;
      else if (w_mul_done)            r_data <= w_prod;
   end

   assign data_o = r_data;
   assign zero_o = r_data == '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized self-checking bench for alu_exec_unit against an arithmetic reference model (honours ALU_MUL_RADIX4_EN)
module tb_alu_exec_unit;
   import alu_pkg::*;

`ifdef ALU_MUL_RADIX4_EN
   localparam int MUL_ITERS = 16;
`else
   localparam int MUL_ITERS = 32;
`endif
   localparam int TMO = 200;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [2:0]  ALUCtrl_i;
   logic [31:0] data1_i;
   logic [31:0] data2_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [31:0] data_o;
   logic        zero_o;
   logic        busy_o;

   int n_checks = 0;
   int n_errors = 0;

   alu_exec_unit dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .ALUCtrl_i    (ALUCtrl_i),
      .data1_i      (data1_i),
      .data2_i      (data2_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .data_o       (data_o),
      .zero_o       (zero_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (code)
         3'b010:  return a + b;
         3'b110:  return a - b;
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b100:  return p[31:0];
         default: return 32'd0;
      endcase
   endfunction

   task automatic wait_accept(input string tag);
      int n = 0;
      while (!req_ready_o && n < TMO) begin
         @(posedge clk_i); #1;
         n++;
      end
      check({tag, "_acc"}, 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
   endtask

   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid_o && lat < TMO) begin
         @(posedge clk_i); #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a, input logic [31:0] b, input int stall);
      logic [31:0] exp;
      int lat;
      exp = ref_alu(code, a, b);
      req_valid_i = 1; ALUCtrl_i = code; data1_i = a; data2_i = b; resp_ready_i = 1;
      wait_accept(tag);
      req_valid_i = 0;
      resp_ready_i = (stall == 0);
      wait_resp(lat);
      check({tag, "_lat"}, 32'(lat), code == 3'b100 ? 32'(MUL_ITERS + 1) : 32'd1);
      check({tag, "_data"}, data_o, exp);
      check({tag, "_zero"}, 32'(zero_o), 32'(exp == 0));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk_i); #1;
         check({tag, "_hold"}, data_o, exp);
         check({tag, "_hvalid"}, 32'(resp_valid_o), 32'd1);
      end
      resp_ready_i = 1;
   endtask

   initial begin
      int lat;
      rst_i = 0; req_valid_i = 0; ALUCtrl_i = 0; data1_i = 0; data2_i = 0; resp_ready_i = 1;
      #2 rst_i = 1;
      #1;
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_valid", 32'(resp_valid_o), 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_zero", 32'(zero_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i); #1 rst_i = 0;

      run_op("add", ALU_ADD, 32'd5, 32'd7, 0);
      run_op("sub", ALU_SUB, 32'd3, 32'd5, 0);
      run_op("and", ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      run_op("or", ALU_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
      run_op("undef", 3'b111, 32'hF0F0F0F0, 32'h0FF00FF0, 1);

      // mul with a second request held throughout: must only be taken in DONE
      req_valid_i = 1; ALUCtrl_i = ALU_MUL; data1_i = 32'hFFFFFFFF; data2_i = 32'd3; resp_ready_i = 1;
      wait_accept("mul");
      ALUCtrl_i = ALU_ADD; data1_i = 32'd100; data2_i = 32'd23;
      lat = 1;
      while (!resp_valid_o && lat < TMO) begin
         check("mul_busy", 32'(busy_o), 32'd1);
         check("mul_ready", 32'(req_ready_o), 32'd0);
         @(posedge clk_i); #1;
         lat++;
      end
      check("mul_lat", 32'(lat), 32'(MUL_ITERS + 1));
      check("mul_data", data_o, 32'hFFFFFFFD);
      check("mul_done_ready", 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 0;
      check("held_add", data_o, 32'd123);
      check("held_valid", 32'(resp_valid_o), 32'd1);

      run_op("mul_zero", ALU_MUL, 32'd0, 32'h12345678, 0);

      // backpressure after a mul, with a pending request that must wait
      req_valid_i = 1; ALUCtrl_i = ALU_MUL; data1_i = 32'd1234; data2_i = 32'd5678;
      wait_accept("bp");
      ALUCtrl_i = ALU_OR; data1_i = 32'd1; data2_i = 32'd2; resp_ready_i = 0;
      wait_resp(lat);
      check("bp_lat", 32'(lat), 32'(MUL_ITERS + 1));
      for (int i = 0; i < 10; i++) begin
         check("bp_data", data_o, 32'd7006652);
         check("bp_valid", 32'(resp_valid_o), 32'd1);
         check("bp_ready", 32'(req_ready_o), 32'd0);
         @(posedge clk_i); #1;
      end
      resp_ready_i = 1;
      #1;
      check("bp_ready_rise", 32'(req_ready_o), 32'd1);
      @(posedge clk_i); #1;
      req_valid_i = 0;
      check("bp_next", data_o, 32'd3);

      // reset asserted ten cycles into a mul
      req_valid_i = 1; ALUCtrl_i = ALU_MUL; data1_i = 32'hDEAD; data2_i = 32'hBEEF;
      wait_accept("mrst");
      req_valid_i = 0;
      repeat (9) @(posedge clk_i);
      #1 rst_i = 1;
      #1;
      check("mrst_ready", 32'(req_ready_o), 32'd1);
      check("mrst_valid", 32'(resp_valid_o), 32'd0);
      check("mrst_data", data_o, 32'd0);
      check("mrst_zero", 32'(zero_o), 32'd1);
      check("mrst_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i); #1 rst_i = 0;
      run_op("post_rst_add", ALU_ADD, 32'd1, 32'd1, 0);

      for (int i = 0; i < 30; i++) begin
         logic [2:0] code;
         logic [31:0] a, b;
         code = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         run_op("rnd", code, a, b, int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
